fetch_queue: RTL and testbench

- Parametrised prefetching instruction fetcher.
- Keeps up to DEPTH sequential instructions buffered ahead of the Decoder, with at most one outstanding InstCache request.
- Supports redirects from the Decoder and flushes from the ROB.
- Sits between InstCache and Decoder and replaces the single-entry fetcher.

---
 rtl/fetch_queue_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared defaults for the prefetching instruction fetcher.
package fetch_queue_pkg;

    localparam int unsigned FQ_ADDR_WIDTH = 32;
    localparam int unsigned FQ_INST_WIDTH = 32;
    localparam int unsigned FQ_DEPTH      = 4;
    localparam int unsigned INST_BYTES    = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instruction, address} entries with push, pop, clear and count.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetcher: one outstanding InstCache request, DEPTH-entry queue toward the Decoder.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned           ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter  int unsigned           INST_WIDTH = FQ_INST_WIDTH,
    parameter  int unsigned           DEPTH      = FQ_DEPTH,
    parameter  logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    localparam int unsigned           CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  dec_ready,
    output logic                  inst_valid_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_addr_out,
    input  logic                  dec_redirect,
    input  logic [ADDR_WIDTH-1:0] dec_redirect_pc,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_handle,
    input  logic                  inst_ready_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic                  rob_clear,
    input  logic [ADDR_WIDTH-1:0] rob_rst_addr,
    output logic [CW-1:0]         count_out
);

    localparam int unsigned EW = INST_WIDTH + ADDR_WIDTH;
    localparam int unsigned FW = CW + 1;

    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  pending;
    logic                  discard;

    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic [FW-1:0]         inflight;
    logic                  accept;
    logic                  resp;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         head;

    // Request only when a queue slot is reserved for the response.
    always_comb begin
        flush          = 1'b0;
        flush_pc       = '0;
        inflight       = '0;
        inst_req       = 1'b0;
        inst_addr      = '0;
        accept         = 1'b0;
        resp           = 1'b0;
        push           = 1'b0;
        inst_valid_out = 1'b0;
        pop            = 1'b0;

        flush          = rdy_in & (rob_clear | dec_redirect);
        flush_pc       = rob_clear ? rob_rst_addr : dec_redirect_pc;
        inflight       = {1'b0, count_out} + FW'(pending);
        inst_req       = rst_in & rdy_in & ~pending & ~rob_clear & ~dec_redirect
                       & (inflight < FW'(DEPTH));
        inst_addr      = {fpc[ADDR_WIDTH-1:2], 2'b00};
        accept         = inst_req & inst_handle;
        resp           = rdy_in & pending & inst_ready_in;
        push           = resp & ~discard & ~flush;
        inst_valid_out = (count_out != '0) & ~rob_clear;
        pop            = rdy_in & inst_valid_out & dec_ready & ~flush;
    end

    // A flush with the response still outstanding marks it for dropping.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fpc       <= RESET_PC;
            resp_addr <= '0;
            pending   <= 1'b0;
            discard   <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                fpc <= flush_pc;
            end else if (accept) begin
                fpc       <= fpc + ADDR_WIDTH'(INST_BYTES);
                resp_addr <= inst_addr;
            end
            if (resp) begin
                pending <= 1'b0;
            end else if (accept) begin
                pending <= 1'b1;
            end
            if (resp) begin
                discard <= 1'b0;
            end else if (flush && pending) begin
                discard <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (push),
        .push_data ({inst_in, resp_addr}),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .count     (count_out)
    );

    assign inst_out      = head[EW-1:ADDR_WIDTH];
    assign inst_addr_out = head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a fixed-latency InstCache model.
module tb_fetch_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          dec_ready;
    logic          inst_valid_out;
    logic [IW-1:0] inst_out;
    logic [AW-1:0] inst_addr_out;
    logic          dec_redirect;
    logic [AW-1:0] dec_redirect_pc;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_handle;
    logic          inst_ready_in;
    logic [IW-1:0] inst_in;
    logic          rob_clear;
    logic [AW-1:0] rob_rst_addr;
    logic [2:0]    count_out;

    fetch_queue #(
        .ADDR_WIDTH (AW),
        .INST_WIDTH (IW),
        .DEPTH      (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .dec_ready       (dec_ready),
        .inst_valid_out  (inst_valid_out),
        .inst_out        (inst_out),
        .inst_addr_out   (inst_addr_out),
        .dec_redirect    (dec_redirect),
        .dec_redirect_pc (dec_redirect_pc),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_handle     (inst_handle),
        .inst_ready_in   (inst_ready_in),
        .inst_in         (inst_in),
        .rob_clear       (rob_clear),
        .rob_rst_addr    (rob_rst_addr),
        .count_out       (count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int errors  = 0;

    // Model state: expected entry stream, delivered count, outstanding request.
    logic [31:0] exp_q[$];
    logic [31:0] model_fpc;
    int          arrived;
    bit          pend;
    bit          live;
    // InstCache model
    bit          resp_active;
    logic [31:0] resp_a;
    int          resp_due;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        arrived   = 0;
        pend      = 0;
        live      = 0;
        model_fpc = '0;
    endtask

    // One clock: check at negedge, advance model and cache just after posedge.
    task automatic cycle();
        bit          ev;
        bit          er;
        bit          acc;
        bit          popm;
        bit          flush;
        bit          taken;
        logic [31:0] ftarget;
        ev = 0;
        er = 0;
        @(negedge clk_in);
        if (rst_in) begin
            ev = (arrived != 0) && !rob_clear;
            er = rdy_in && !pend && !rob_clear && !dec_redirect
               && (arrived + int'(pend) < int'(DEPTH));
            check("valid", 32'(inst_valid_out), 32'(ev));
            check("count", 32'(count_out), 32'(arrived));
            check("req",   32'(inst_req), 32'(er));
        end
        acc = er && inst_handle;
        if (acc) check("req_addr", inst_addr, {model_fpc[31:2], 2'b00});
        flush = rst_in && rdy_in && (rob_clear || dec_redirect);
        popm  = rdy_in && ev && dec_ready && !flush;
        if (popm) begin
            if (exp_q.size() == 0) begin
                check("pop_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                check("head_addr", inst_addr_out, exp_q[0]);
                check("head_data", inst_out, data_of(exp_q[0]));
            end
        end
        taken   = rst_in && rdy_in && inst_ready_in;
        ftarget = rob_clear ? rob_rst_addr : dec_redirect_pc;
        @(posedge clk_in);
        cyc++;
        #1;
        if (popm && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            arrived--;
        end
        if (taken && pend) begin
            pend = 0;
            if (live && !flush) arrived++;
        end
        if (flush) begin
            exp_q.delete();
            arrived   = 0;
            live      = 0;
            model_fpc = ftarget;
        end else if (acc) begin
            exp_q.push_back({model_fpc[31:2], 2'b00});
            model_fpc = model_fpc + 32'd4;
            pend      = 1;
            live      = 1;
        end
        if (taken) resp_active = 0;
        if (acc) begin
            resp_active = 1;
            resp_a      = exp_q[$];
            resp_due    = cyc + 3;
        end
        inst_ready_in = resp_active && (cyc + 1 >= resp_due);
        inst_in       = data_of(resp_a);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp);
        bit f;
        f = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (inst_valid_out) begin
                check(tag, inst_addr_out, exp);
                f = 1;
                break;
            end
        end
        if (!f) check({tag, "_timeout"}, 32'(f), 32'd1);
    endtask

    initial begin
        bit          found;
        bit          seen40;
        int          n;
        logic [2:0]  s_count;
        logic [31:0] s_addr;
        logic        s_valid;
        int          r;

        rst_in          = 1'b0;
        rdy_in          = 1'b1;
        dec_ready       = 1'b0;
        dec_redirect    = 1'b0;
        dec_redirect_pc = '0;
        inst_handle     = 1'b0;
        inst_ready_in   = 1'b0;
        inst_in         = '0;
        rob_clear       = 1'b0;
        rob_rst_addr    = '0;
        resp_active     = 0;
        resp_a          = '0;
        resp_due        = 0;
        cyc             = 0;
        model_reset();

        // Reset state
        #2;
        check("rst_valid", 32'(inst_valid_out), 32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_req",   32'(inst_req), 32'd0);
        repeat (3) cycle();

        // Straight-line stream from RESET_PC; first valid 4 cycles after release
        inst_handle = 1'b1;
        dec_ready   = 1'b1;
        rst_in      = 1'b1;
        n = 0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (inst_valid_out) begin
                n = i;
                found = 1;
                break;
            end
        end
        check("first_valid_lat", 32'(n), 32'd4);
        check("first_valid_addr", inst_addr_out, 32'h0);
        repeat (12) cycle();

        // Fill the queue with the decoder stalled
        rob_clear    = 1'b1;
        rob_rst_addr = 32'h0;
        cycle();
        rob_clear = 1'b0;
        dec_ready = 1'b0;
        repeat (30) cycle();
        check("full_count", 32'(count_out), 32'd4);
        check("full_req",   32'(inst_req), 32'd0);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        check("after_pop_count", 32'(count_out), 32'd3);
        check("next_req",  32'(inst_req), 32'd1);
        check("next_addr", inst_addr, 32'h10);
        dec_ready = 1'b1;
        repeat (6) cycle();

        // Flush while the request for 0x8 is outstanding
        rob_clear    = 1'b1;
        rob_rst_addr = 32'h0;
        cycle();
        rob_clear = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (resp_active && resp_a == 32'h8 && resp_due == cyc + 3) begin
                found = 1;
                break;
            end
        end
        check("pend8_seen", 32'(found), 32'd1);
        rob_clear    = 1'b1;
        rob_rst_addr = 32'h100;
        cycle();
        rob_clear    = 1'b0;
        rob_rst_addr = 32'h0;
        check("flush_count", 32'(count_out), 32'd0);
        check("flush_valid", 32'(inst_valid_out), 32'd0);
        wait_valid("flush_first_addr", 32'h100);
        repeat (4) cycle();

        // rob_clear beats dec_redirect in the same cycle
        rob_clear       = 1'b1;
        rob_rst_addr    = 32'h200;
        dec_redirect    = 1'b1;
        dec_redirect_pc = 32'h40;
        cycle();
        rob_clear    = 1'b0;
        dec_redirect = 1'b0;
        wait_valid("both_first_addr", 32'h200);
        seen40 = 0;
        repeat (15) begin
            cycle();
            if (inst_valid_out && inst_addr_out == 32'h40) seen40 = 1;
        end
        check("no_0x40", 32'(seen40), 32'd0);

        // rdy_in low freezes everything
        dec_ready = 1'b0;
        repeat (5) cycle();
        s_count = count_out;
        s_addr  = inst_addr_out;
        s_valid = inst_valid_out;
        rdy_in      = 1'b0;
        inst_handle = 1'b1;
        dec_ready   = 1'b1;
        repeat (3) begin
            cycle();
            check("hold_count", 32'(count_out), 32'(s_count));
            check("hold_addr",  inst_addr_out, s_addr);
            check("hold_valid", 32'(inst_valid_out), 32'(s_valid));
            check("hold_req",   32'(inst_req), 32'd0);
        end
        rdy_in = 1'b1;
        repeat (20) cycle();

        // Randomised mix of stalls, handshakes, redirects and flushes
        for (int i = 0; i < 200; i++) begin
            dec_ready       = 1'($urandom_range(0, 1));
            inst_handle     = ($urandom_range(0, 3) != 0);
            rdy_in          = ($urandom_range(0, 7) != 0);
            r               = int'($urandom_range(0, 31));
            rob_clear       = (r == 0);
            dec_redirect    = (r == 1 || r == 2);
            rob_rst_addr    = 32'($urandom_range(0, 1023)) << 2;
            dec_redirect_pc = 32'($urandom_range(0, 1023)) << 2;
            cycle();
        end
        rob_clear    = 1'b0;
        dec_redirect = 1'b0;
        rdy_in       = 1'b1;
        inst_handle  = 1'b1;
        repeat (10) cycle();

        // Asynchronous reset with a request pending and three entries queued
        rob_clear    = 1'b1;
        rob_rst_addr = 32'h0;
        cycle();
        rob_clear = 1'b0;
        dec_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (count_out == 3'd3 && pend) begin
                found = 1;
                break;
            end
        end
        check("pre_rst_state", 32'(found), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(inst_valid_out), 32'd0);
        check("async_rst_count", 32'(count_out), 32'd0);
        check("async_rst_req",   32'(inst_req), 32'd0);
        model_reset();
        inst_handle = 1'b0;
        repeat (2) cycle();
        rst_in = 1'b1;
        repeat (2) cycle();
        inst_handle = 1'b1;
        dec_ready   = 1'b1;
        wait_valid("post_rst_addr", 32'h0);
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
